// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_control                                            |
// | Purpose  : Main control FSM of the 16-bit multicycle processor. Steps     |
// |            each instruction through fetch, decode, execute, memory and   |
// |            writeback, drives the datapath strobes and the ALUOp/funct    |
// |            pair for the ALU control decoder, stalls on mem_ready and     |
// |            counts retired instructions.                                  |
// | Ports    : clock, reset_n (sync, active-low), instruction[15:0],         |
// |            mem_ready -> pc_write, pc_write_cond, ior_d, mem_read,        |
// |            mem_write, ir_write, reg_write, reg_dst, mem_to_reg,          |
// |            alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[1:0],       |
// |            alu_funct[2:0], halted, retired[CNT_W-1:0], state[3:0]        |
// | Options  : define ILLEGAL_TRAP_EN to make undefined opcodes load the     |
// |            trap vector (not retired) instead of acting as a retired NOP. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multicycle_control #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      instruction,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [2:0]       alu_funct,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_WB_MEM   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_EXEC_I   = 4'd9;
  localparam logic [3:0] S_WB_I     = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_BNE  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_J    = 4'b0110;

  logic [3:0] cur_state;
  logic [3:0] next_state;
  logic       retire;
  logic [3:0] opcode;
  logic       unused_bits;

  assign opcode      = instruction[15:12];
  assign state       = cur_state;
  // Only opcode and funct fields steer control; the register fields do not.
  assign unused_bits = ^instruction[11:3];

  // Next state and retire decision
  always_comb begin
    next_state = cur_state;
    retire     = 1'b0;
    case (cur_state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:           next_state = S_EXEC_R;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_ADDI:        next_state = S_EXEC_I;
          OP_J:           next_state = S_JUMP;
          default:        next_state = (opcode == HALT_OP) ? S_HALT : S_ILLEGAL;
        endcase
      end
      // IR still holds the instruction, so the opcode picks the access type.
      S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) next_state = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_EXEC_R:   next_state = S_WB_R;
      S_EXEC_I:   next_state = S_WB_I;
      S_HALT:     next_state = S_HALT;
      S_ILLEGAL: begin
        next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        retire     = 1'b0;
`else
        retire     = 1'b1;
`endif
      end
      default:    next_state = S_IDLE;
    endcase
  end

  // Datapath strobes; Moore except pc_write in FETCH and funct selection
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 2'b00;
    alu_funct     = 3'b000;
    halted        = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        // PC+1 is committed only when the fetch actually completes.
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ior_d    = 1'b1;
        mem_read = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ior_d     = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        alu_funct = instruction[2:0];
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_WB_I:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        alu_funct     = (opcode == OP_BNE) ? 3'b010 : 3'b000;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_HALT:     halted = 1'b1;
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        pc_write  = 1'b1;
        pc_source = 2'b11;
`else
        pc_write  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state <= S_IDLE;
      retired   <= '0;
    end else begin
      cur_state <= next_state;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multicycle_control                                         |
// | Purpose  : Self-checking bench for multicycle_control. Each instruction  |
// |            is expanded into its expected cycle-by-cycle trace from the   |
// |            opcode and the chosen memory stall counts, and the DUT state, |
// |            strobes and retired count are compared every cycle.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;

  localparam int unsigned CNT_W   = 4;   // small so the wrap is exercised
  localparam logic [3:0]  HALT_OP = 4'b1111;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2,
                         MEM_ADDR = 4'd3, MEM_RD = 4'd4, WB_MEM = 4'd5,
                         MEM_WR = 4'd6, EXEC_R = 4'd7, WB_R = 4'd8,
                         EXEC_I = 4'd9, WB_I = 4'd10, BRANCH = 4'd11,
                         JUMP = 4'd12, HALT = 4'd13, ILLEGAL = 4'd14;

  // Packed view of all control outputs:
  // {pcw,pcwc,iord,mr,mw,irw,rw,rd,m2r,asa,asb[2],pcs[2],aop[2],fn[3],halted}
  localparam logic [19:0] M_PCW  = 20'h80000;
  localparam logic [19:0] M_PCWC = 20'h40000;
  localparam logic [19:0] M_IORD = 20'h20000;
  localparam logic [19:0] M_MR   = 20'h10000;
  localparam logic [19:0] M_MW   = 20'h08000;
  localparam logic [19:0] M_IRW  = 20'h04000;
  localparam logic [19:0] M_RW   = 20'h02000;
  localparam logic [19:0] M_RD   = 20'h01000;
  localparam logic [19:0] M_M2R  = 20'h00800;
  localparam logic [19:0] M_ASA  = 20'h00400;
  localparam logic [19:0] M_HALT = 20'h00001;

  logic             clock, reset_n, mem_ready;
  logic [15:0]      instruction;
  logic             pc_write, pc_write_cond, ior_d, mem_read, mem_write;
  logic             ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]       alu_src_b, pc_source, alu_op;
  logic [2:0]       alu_funct;
  logic             halted;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;
  logic [19:0]      ctl_obs;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_ret;

  multicycle_control #(.CNT_W(CNT_W), .HALT_OP(HALT_OP)) dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .alu_funct(alu_funct),
    .halted(halted), .retired(retired), .state(state)
  );

  assign ctl_obs = {pc_write, pc_write_cond, ior_d, mem_read, mem_write,
                    ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                    alu_src_b, pc_source, alu_op, alu_funct, halted};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] mux(input logic [1:0] asb, input logic [1:0] pcs,
                                      input logic [1:0] aop, input logic [2:0] fn);
    return {10'b0, asb, pcs, aop, fn, 1'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [19:0] ctl);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " ctl"}, 32'(ctl_obs), 32'(ctl));
    check({tag, " retired"}, 32'(retired), 32'(exp_ret));
  endtask

  // One clock cycle: apply mem_ready for the cycle, compare mid-cycle, then
  // account for a retirement that lands on the closing edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic rdy,
                     input logic [19:0] ctl, input bit ret);
    @(posedge clock); #1;
    mem_ready = rdy;
    @(negedge clock);
    check_all(tag, st, ctl);
    if (ret) exp_ret = exp_ret + 1'b1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    exp_ret = '0;
    check_all("reset_low", IDLE, 20'h0);
    reset_n = 1'b1;
    @(negedge clock);
    check_all("idle", IDLE, 20'h0);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn,
                           input int fs, input int ms);
    logic [31:0] r;
    logic [19:0] fetch_ctl;
    r           = $urandom;
    instruction = {op, r[8:0], fn};
    fetch_ctl   = M_MR | M_IRW | mux(2'b01, 2'b00, 2'b00, 3'b000);
    for (int i = 0; i < fs; i++) cyc("fetch_wait", FETCH, 1'b0, fetch_ctl, 1'b0);
    cyc("fetch", FETCH, 1'b1, fetch_ctl | M_PCW, 1'b0);
    cyc("decode", DECODE, rb(), mux(2'b11, 2'b00, 2'b00, 3'b000), 1'b0);
    case (op)
      4'b0000: begin
        cyc("exec_r", EXEC_R, rb(), M_ASA | mux(2'b00, 2'b00, 2'b10, fn), 1'b0);
        cyc("wb_r", WB_R, rb(), M_RW | M_RD, 1'b1);
      end
      4'b0001: begin
        cyc("mem_addr", MEM_ADDR, rb(), M_ASA | mux(2'b10, 2'b00, 2'b00, 3'b000), 1'b0);
        for (int i = 0; i < ms; i++) cyc("mem_rd_wait", MEM_RD, 1'b0, M_IORD | M_MR, 1'b0);
        cyc("mem_rd", MEM_RD, 1'b1, M_IORD | M_MR, 1'b0);
        cyc("wb_mem", WB_MEM, rb(), M_RW | M_M2R, 1'b1);
      end
      4'b0010: begin
        cyc("mem_addr", MEM_ADDR, rb(), M_ASA | mux(2'b10, 2'b00, 2'b00, 3'b000), 1'b0);
        for (int i = 0; i < ms; i++) cyc("mem_wr_wait", MEM_WR, 1'b0, M_IORD | M_MW, 1'b0);
        cyc("mem_wr", MEM_WR, 1'b1, M_IORD | M_MW, 1'b1);
      end
      4'b0011, 4'b0100:
        cyc("branch", BRANCH, rb(),
            M_ASA | M_PCWC | mux(2'b00, 2'b01, 2'b01, (op == 4'b0100) ? 3'b010 : 3'b000), 1'b1);
      4'b0101: begin
        cyc("exec_i", EXEC_I, rb(), M_ASA | mux(2'b10, 2'b00, 2'b11, 3'b000), 1'b0);
        cyc("wb_i", WB_I, rb(), M_RW, 1'b1);
      end
      4'b0110: cyc("jump", JUMP, rb(), M_PCW | mux(2'b00, 2'b10, 2'b00, 3'b000), 1'b1);
      default: begin
        if (op == HALT_OP) begin
          for (int i = 0; i < 5; i++) cyc("halt", HALT, rb(), M_HALT, 1'b0);
        end else begin
`ifdef ILLEGAL_TRAP_EN
          cyc("illegal", ILLEGAL, rb(), M_PCW | mux(2'b00, 2'b11, 2'b00, 3'b000), 1'b0);
`else
          cyc("illegal", ILLEGAL, rb(), 20'h0, 1'b1);
`endif
        end
      end
    endcase
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] r;
    instruction = 16'h0000;
    exp_ret     = '0;
    do_reset();

    // Directed cases
    run_instr(4'b0000, 3'b000, 0, 0);   // ADD
    run_instr(4'b0001, 3'b000, 3, 3);   // LW with stalls in FETCH and MEM_RD
    run_instr(4'b0100, 3'b000, 0, 0);   // BNE
    run_instr(4'b0011, 3'b000, 0, 0);   // BEQ
    run_instr(4'b0111, 3'b000, 0, 0);   // undefined opcode
    run_instr(4'b0010, 3'b000, 2, 2);   // SW with stalls

    // Random instruction stream (HALT excluded), long enough to wrap retired
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 14));
      r  = $urandom;
      run_instr(op, r[2:0], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a load: no writeback, count cleared
    instruction = 16'h1000;
    cyc("abort_fetch", FETCH, 1'b1, M_MR | M_IRW | M_PCW | mux(2'b01, 2'b00, 2'b00, 3'b000), 1'b0);
    cyc("abort_decode", DECODE, 1'b0, mux(2'b11, 2'b00, 2'b00, 3'b000), 1'b0);
    cyc("abort_addr", MEM_ADDR, 1'b0, M_ASA | mux(2'b10, 2'b00, 2'b00, 3'b000), 1'b0);
    cyc("abort_rd", MEM_RD, 1'b0, M_IORD | M_MR, 1'b0);
    do_reset();
    run_instr(4'b0101, 3'b000, 1, 0);   // ADDI after reset

    // Halt, then recover by reset
    run_instr(HALT_OP, 3'b000, 0, 0);
    do_reset();
    run_instr(4'b0000, 3'b101, 0, 0);
    run_instr(4'b0110, 3'b000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
